alu_pipe: RTL
=============

# alu_pipe

Parametrised, handshaked successor to the combinational datapath ALU. Accepts one operation per transaction through a valid/ready input port and delivers a registered result through a valid/ready output port. Owns the processor status flag register, so ADDC carry chaining and flag persistence happen here instead of in the controller. Single-cycle ops complete in one clock. MUL runs an iterative shift-add sequence. Sits between the register file read ports and the writeback mux.

## Interface
- WIDTH, 16: datapath width; must be ≥ 4.
- SHW, $clog2(WIDTH)+1: width of the signed shift-amount field taken from b[SHW-1:0].
- clk  in  1  sole clock, rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  operation presented.
- in_ready  out  1  ALU can accept; reset 0 while asserted, 1 after release.
- op  in  4  alu_op_t code.
- a, b  in  WIDTH  operands.
- out_valid  out  1  result held; reset 0.
- out_ready  in  1  consumer accepts result.
- result  out  WIDTH  registered result; reset 0.
- flags  out  6  status register {INV,N,Z,F,L,C}; reset 0.
- busy  out  1  MUL iteration in progress; reset 0.

## Operation
- FSM states: IDLE, MUL, HOLD.
- in_ready = (state==IDLE) && (!out_valid || out_ready).
- Accept happens when in_valid && in_ready.
- Single-cycle ops on accept: result, flags and out_valid are written at the same edge.
- ADD: C = carry-out. F = signed overflow. Z, N from result.
- ADDC: as ADD, plus carry-in = flags.C at the accept cycle.
- SUB: result = a-b. C = borrow. F = signed overflow. Z, N set.
- CMP: result = 0. L = (a<b) unsigned. N = (a<b) signed. Z = (a==b). C, F keep their values.
- AND, OR, XOR, MOV(b): update Z and N only.
- LSH: amount s = signed b[SHW-1:0]. s>0 shifts left, s<0 shifts right logically. |s| ≥ WIDTH gives 0. Updates Z and N.
- ASH: same as LSH, but right shifts fill with the sign bit. |s| ≥ WIDTH fills the whole result with the sign bit.
- MUL is signed. On accept it latches the operands and enters MUL for WIDTH cycles, one radix-2 step per cycle on a 2·WIDTH-bit accumulator.
- MUL completion: result = low WIDTH bits. F = product does not fit signed WIDTH. Z, N from result.
- Any op not updating a flag leaves that flag unchanged. This is a deliberate behaviour change from the old ALU, which cleared all flags on every op.
- INV is set, and only INV changes, on an undefined op code. The op completes in one cycle with result = 0.
- HOLD: the result is ready but out_valid && !out_ready. The FSM returns to IDLE when out_ready is seen.
- Single-cycle ops never enter HOLD. in_ready already blocks them while out_valid && !out_ready.
- reset_n low at any time, including mid-MUL: the FSM goes to IDLE, all outputs and the accumulator clear asynchronously, and the partial product is discarded.

## Timing
- Single-cycle op latency: accept at edge k → out_valid and result visible after edge k.
- Back-to-back ops at one per cycle are allowed while out_ready = 1.
- ADDC issued the cycle after an ADD sees that ADD's carry.
- MUL latency: accept at edge k → result after edge k+WIDTH. in_ready = 0 during that time.
- out_valid clears on the edge where out_ready = 1, unless a new accept occurs on the same edge.
- result and flags are stable while out_valid && !out_ready.
- flags stay readable after out_valid drops.

## Structure
- Package alu_pkg holds:
  - alu_op_t enum: ADD=0, ADDC=1, SUB=2, CMP=3, AND=4, OR=5, XOR=6, MOV=7, LSH=8, ASH=9, MUL=10; 11–15 invalid.
  - Flag index constants: C=0, L=1, F=2, Z=3, N=4, INV=5.
  - FSM state typedef.
- Sub-module alu_mul_seq holds the iterative multiplier: start/done handshake, WIDTH-cycle counter, accumulator.
- The top level holds the combinational single-cycle datapath, the flag register and the handshake FSM.

## Test plan
- ADD a=16'h7FFF, b=1 → result 16'h8000, F=1, N=1, C=0, Z=0. Then AND a=16'hFFFF, b=0 → result 0, Z=1, F still 1.
- ADD 16'hFFFF+1 (C=1), then ADDC 0+0 on the next cycle → result 1, C=0. Must sustain one op per cycle with out_ready=1.
- CMP a=16'hFFFF, b=1 → L=0, N=1, Z=0, result 0. LSH a=16'h0F00, b=-4 → 16'h00F0. ASH a=16'h8000, b=-15 → 16'hFFFF.
- MUL a=-3, b=7 → result 16'hFFEB, F=0, out_valid exactly 16 cycles after accept. MUL 16'h4000×4 → result 0, F=1, Z=1.
- Hold out_ready=0 for 5 cycles after a result → result and flags stable, in_ready=0. Release → accept resumes the next cycle.
- Assert reset_n low at MUL cycle 7 → busy, out_valid, result and flags are 0 immediately. A fresh ADD after release works. Op 4'hC → INV=1, result 0.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared types for the handshaked ALU: op codes, flag bit positions, FSM states.
package alu_pkg;

    typedef enum logic [3:0] {
        OP_ADD  = 4'd0,
        OP_ADDC = 4'd1,
        OP_SUB  = 4'd2,
        OP_CMP  = 4'd3,
        OP_AND  = 4'd4,
        OP_OR   = 4'd5,
        OP_XOR  = 4'd6,
        OP_MOV  = 4'd7,
        OP_LSH  = 4'd8,
        OP_ASH  = 4'd9,
        OP_MUL  = 4'd10
    } alu_op_t;

    localparam int FLAG_C    = 0;
    localparam int FLAG_L    = 1;
    localparam int FLAG_F    = 2;
    localparam int FLAG_Z    = 3;
    localparam int FLAG_N    = 4;
    localparam int FLAG_INV  = 5;
    localparam int NUM_FLAGS = 6;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_HOLD = 2'd2
    } state_t;

endpackage

// File: rtl/alu_mul_seq.sv
// Iterative signed multiplier, one radix-2 step per cycle; start -> done after WIDTH steps.
// product carries the accumulator's next value, so it is the full product in the done cycle.
module alu_mul_seq #(
    parameter int WIDTH = 16
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               start,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic               busy,
    output logic               done,
    output logic [2*WIDTH-1:0] product
);
    localparam int CW = $clog2(WIDTH);

    logic [2*WIDTH-1:0] acc;
    logic [2*WIDTH-1:0] mcand;
    logic [2*WIDTH-1:0] term;
    logic [2*WIDTH-1:0] acc_nxt;
    logic [WIDTH-1:0]   mplier;
    logic [CW-1:0]      cnt;
    logic               last;

    assign last = (cnt == CW'(WIDTH - 1));

    // The multiplier MSB carries weight -2^(WIDTH-1), so the final step subtracts.
    always_comb begin
        term    = mplier[0] ? mcand : '0;
        acc_nxt = last ? (acc - term) : (acc + term);
    end

    assign done    = busy && last;
    assign product = acc_nxt;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            busy   <= 1'b0;
            acc    <= '0;
            mcand  <= '0;
            mplier <= '0;
            cnt    <= '0;
        end else if (start) begin
            busy   <= 1'b1;
            acc    <= '0;
            mcand  <= {{WIDTH{a[WIDTH-1]}}, a};
            mplier <= b;
            cnt    <= '0;
        end else if (busy) begin
            acc    <= acc_nxt;
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
            cnt    <= cnt + CW'(1);
            if (last) begin
                busy <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/alu_pipe.sv
// Handshaked ALU with persistent status flags; single-cycle ops land one edge after accept,
// MUL after WIDTH edges. in_ready drops while a result is held unconsumed or MUL is running.
module alu_pipe
    import alu_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int SHW   = $clog2(WIDTH) + 1
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [3:0]           op,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [WIDTH-1:0]     result,
    output logic [NUM_FLAGS-1:0] flags,
    output logic                 busy
);
    localparam int MSB = WIDTH - 1;
    localparam logic [SHW:0] WLIM = (SHW + 1)'(WIDTH);

    state_t               state;
    state_t               state_nxt;
    logic                 alive;
    logic                 accept;
    logic                 is_mul;
    logic                 mul_start;
    logic                 mul_done;
    logic [2*WIDTH-1:0]   mul_prod;
    logic [WIDTH-1:0]     mul_res;
    logic [NUM_FLAGS-1:0] mul_flags;

    logic                 cin;
    logic [WIDTH:0]       add_full;
    logic [WIDTH:0]       sub_full;
    logic [SHW-1:0]       sh_raw;
    logic                 sh_neg;
    logic [SHW-1:0]       sh_mag;
    logic                 sh_big;
    logic [WIDTH-1:0]     lsh_res;
    logic [WIDTH-1:0]     ash_res;
    logic [WIDTH-1:0]     alu_res;
    logic [NUM_FLAGS-1:0] flags_nxt;
    logic                 upd_zn;

    assign is_mul = (op == OP_MUL);
    assign accept = in_valid && in_ready;

    // Add/subtract share one carry chain per direction; ADDC chains the stored carry.
    assign cin      = (op == OP_ADDC) ? flags[FLAG_C] : 1'b0;
    assign add_full = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, cin};
    assign sub_full = {1'b0, a} - {1'b0, b};

    // Shift amount is a signed field; magnitude equal to or beyond WIDTH saturates.
    assign sh_raw  = b[SHW-1:0];
    assign sh_neg  = sh_raw[SHW-1];
    assign sh_mag  = sh_neg ? (-sh_raw) : sh_raw;
    assign sh_big  = ({1'b0, sh_mag} >= WLIM);
    assign lsh_res = sh_big ? '0 : (sh_neg ? (a >> sh_mag) : (a << sh_mag));
    assign ash_res = sh_big ? {WIDTH{a[MSB]}}
                   : (sh_neg ? $unsigned($signed(a) >>> sh_mag) : (a << sh_mag));

    always_comb begin
        alu_res   = '0;
        flags_nxt = flags;
        upd_zn    = 1'b0;
        case (op)
            OP_ADD, OP_ADDC: begin
                alu_res           = add_full[MSB:0];
                flags_nxt[FLAG_C] = add_full[WIDTH];
                flags_nxt[FLAG_F] = (a[MSB] == b[MSB]) && (add_full[MSB] != a[MSB]);
                upd_zn            = 1'b1;
            end
            OP_SUB: begin
                alu_res           = sub_full[MSB:0];
                flags_nxt[FLAG_C] = sub_full[WIDTH];
                flags_nxt[FLAG_F] = (a[MSB] != b[MSB]) && (sub_full[MSB] != a[MSB]);
                upd_zn            = 1'b1;
            end
            OP_CMP: begin
                flags_nxt[FLAG_L] = sub_full[WIDTH];
                flags_nxt[FLAG_N] = ($signed(a) < $signed(b));
                flags_nxt[FLAG_Z] = (a == b);
            end
            OP_AND: begin
                alu_res = a & b;
                upd_zn  = 1'b1;
            end
            OP_OR: begin
                alu_res = a | b;
                upd_zn  = 1'b1;
            end
            OP_XOR: begin
                alu_res = a ^ b;
                upd_zn  = 1'b1;
            end
            OP_MOV: begin
                alu_res = b;
                upd_zn  = 1'b1;
            end
            OP_LSH: begin
                alu_res = lsh_res;
                upd_zn  = 1'b1;
            end
            OP_ASH: begin
                alu_res = ash_res;
                upd_zn  = 1'b1;
            end
            OP_MUL: begin
                alu_res = '0;
            end
            default: begin
                flags_nxt[FLAG_INV] = 1'b1;
            end
        endcase
        if (upd_zn) begin
            flags_nxt[FLAG_Z] = (alu_res == '0);
            flags_nxt[FLAG_N] = alu_res[MSB];
        end
    end

    alu_mul_seq #(
        .WIDTH (WIDTH)
    ) u_mul (
        .clk     (clk),
        .reset_n (reset_n),
        .start   (mul_start),
        .a       (a),
        .b       (b),
        .busy    (busy),
        .done    (mul_done),
        .product (mul_prod)
    );

    // Overflow when the upper half plus the result sign bit are not a pure sign extension.
    always_comb begin
        mul_res           = mul_prod[MSB:0];
        mul_flags         = flags;
        mul_flags[FLAG_F] = !((&mul_prod[2*WIDTH-1:MSB]) || !(|mul_prod[2*WIDTH-1:MSB]));
        mul_flags[FLAG_Z] = (mul_res == '0);
        mul_flags[FLAG_N] = mul_res[MSB];
    end

    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        mul_start = 1'b0;
        case (state)
            ST_IDLE: begin
                in_ready = alive && (!out_valid || out_ready);
                if (in_valid && in_ready && is_mul) begin
                    mul_start = 1'b1;
                    state_nxt = ST_MUL;
                end
            end
            ST_MUL: begin
                if (mul_done) begin
                    state_nxt = ST_HOLD;
                end
            end
            ST_HOLD: begin
                if (out_ready) begin
                    state_nxt = ST_IDLE;
                end
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= ST_IDLE;
            alive     <= 1'b0;
            out_valid <= 1'b0;
            result    <= '0;
            flags     <= '0;
        end else begin
            state <= state_nxt;
            alive <= 1'b1;
            if (accept && !is_mul) begin
                result    <= alu_res;
                flags     <= flags_nxt;
                out_valid <= 1'b1;
            end else if (mul_done) begin
                result    <= mul_res;
                flags     <= mul_flags;
                out_valid <= 1'b1;
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule
